// File: rtl/int_ctrl_mo.sv
// int_ctrl_mo: sticky interrupt status with edge/level capture, routed
// through per-pin masks to NOUT independent pulse/level interrupt pins.
module int_ctrl_mo #(
    parameter int NW         = 16,
    parameter int NOUT       = 2,
    parameter int WW         = 11,
    parameter int RST_SRC_EN = 1,
    localparam int IDW       = $clog2(NW)
) (
    input  logic                 clk_32k,
    input  logic                 rst,
    input  logic [NW-1:0]        src_in,
    input  logic [NW-1:0]        rg_src_level,
    input  logic [NW-1:0]        rg_int_clr,
    input  logic [NOUT*NW-1:0]   rg_int_enable,
    input  logic [NOUT-1:0]      rg_out_low_en,
    input  logic [NOUT-1:0]      rg_out_level_en,
    input  logic [NOUT*WW-1:0]   rg_out_width,
    input  logic [NOUT*WW-1:0]   rg_out_cold,
    output logic [NW-1:0]        int_status,
    output logic [NOUT*IDW-1:0]  int_src_id,
    output logic [NOUT-1:0]      int_out
);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_COLD} st_t;

    logic [NW-1:0] r_status;
    logic [NW-1:0] r_src_d1;
    logic          r_por;
    logic [NW-1:0] w_set;

    always_comb begin
        w_set = (rg_src_level & src_in) | (~rg_src_level & src_in & ~r_src_d1);
        if (RST_SRC_EN != 0) w_set[0] = w_set[0] | r_por;
    end

    // r_por is held set through reset so the first edge after release
    // raises status[0] as a power-on event.
    always_ff @(posedge clk_32k or posedge rst) begin
        if (rst) begin
            r_status <= '0;
            r_src_d1 <= '0;
            r_por    <= 1'b1;
        end else begin
            r_status <= (r_status & ~rg_int_clr) | w_set;
            r_src_d1 <= src_in;
            r_por    <= 1'b0;
        end
    end

    assign int_status = r_status;

    for (genvar o = 0; o < NOUT; o++) begin : g_out
        st_t             r_state;
        st_t             w_nxt;
        logic [WW-1:0]   r_cnt;
        logic            r_mode;
        logic [IDW-1:0]  r_id;
        logic [IDW-1:0]  w_low;
        logic [NW-1:0]   w_hit;
        logic            w_on;
        logic            w_act;
        logic [WW-1:0]   w_width;
        logic [WW-1:0]   w_cold;
        logic [WW-1:0]   w_wm1;
        logic [WW-1:0]   w_cm1;

        assign w_hit   = r_status & rg_int_enable[o*NW +: NW];
        assign w_on    = |w_hit;
        assign w_width = rg_out_width[o*WW +: WW];
        assign w_cold  = rg_out_cold[o*WW +: WW];
        assign w_wm1   = (w_width == '0) ? '0 : w_width - 1'b1;
        assign w_cm1   = (w_cold == '0) ? '0 : w_cold - 1'b1;

        always_comb begin
            w_low = '0;
            for (int i = NW - 1; i >= 0; i--) begin
                if (w_hit[i]) w_low = IDW'(i);
            end
        end

        always_ff @(posedge clk_32k or posedge rst) begin
            if (rst) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_mode  <= 1'b0;
                r_id    <= '0;
            end else begin
                r_state <= w_nxt;
                if (r_state == S_IDLE && w_nxt == S_ASSERT) begin
                    r_cnt  <= w_wm1;
                    r_mode <= rg_out_level_en[o];
                    r_id   <= w_low;
                end else if (r_state == S_ASSERT && w_nxt == S_COLD) begin
                    r_cnt <= w_cm1;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end

        always_comb begin
            w_nxt = r_state;
            unique case (r_state)
                S_IDLE:   if (w_on) w_nxt = S_ASSERT;
                S_ASSERT: if (r_mode ? !w_on : (r_cnt == '0)) w_nxt = S_COLD;
                S_COLD:   if (r_cnt == '0) w_nxt = S_IDLE;
                default:  w_nxt = S_IDLE;
            endcase
        end

        always_comb begin
            w_act = (r_state == S_ASSERT);
        end

        assign int_out[o]                = w_act ^ rg_out_low_en[o];
        assign int_src_id[o*IDW +: IDW]  = r_id;
    end

endmodule

// File: tb/tb_int_ctrl_mo.sv
// tb_int_ctrl_mo: directed plus random stimulus for int_ctrl_mo against
// a timestamp-based behavioural model of status and pin timing.
module tb_int_ctrl_mo;
    localparam int NW   = 16;
    localparam int NOUT = 2;
    localparam int WW   = 11;
    localparam int IDW  = 4;

    logic                clk_32k = 1'b0;
    logic                rst = 1'b1;
    logic [NW-1:0]       src_in = '0;
    logic [NW-1:0]       rg_src_level = '0;
    logic [NW-1:0]       rg_int_clr = '0;
    logic [NOUT*NW-1:0]  rg_int_enable = '0;
    logic [NOUT-1:0]     rg_out_low_en = '0;
    logic [NOUT-1:0]     rg_out_level_en = '0;
    logic [NOUT*WW-1:0]  rg_out_width = '0;
    logic [NOUT*WW-1:0]  rg_out_cold = '0;
    logic [NW-1:0]       int_status;
    logic [NOUT*IDW-1:0] int_src_id;
    logic [NOUT-1:0]     int_out;

    int_ctrl_mo dut (
        .clk_32k(clk_32k), .rst(rst), .src_in(src_in),
        .rg_src_level(rg_src_level), .rg_int_clr(rg_int_clr),
        .rg_int_enable(rg_int_enable), .rg_out_low_en(rg_out_low_en),
        .rg_out_level_en(rg_out_level_en), .rg_out_width(rg_out_width),
        .rg_out_cold(rg_out_cold), .int_status(int_status),
        .int_src_id(int_src_id), .int_out(int_out)
    );

    always #5 clk_32k = ~clk_32k;

    int total = 0;
    int bad = 0;

    // model: phase 0 idle, 1 active, 2 cold; m_end is the edge that ends it
    logic [NW-1:0]   m_status;
    logic [NW-1:0]   m_d1;
    logic            m_por;
    logic [NOUT-1:0] m_lvl;
    int              m_ph [NOUT];
    longint          m_end [NOUT];
    logic [IDW-1:0]  m_id [NOUT];
    longint          m_cyc = 0;

    function automatic int eff(input logic [WW-1:0] v);
        return (v == '0) ? 1 : int'(v);
    endfunction

    task automatic model_reset();
        m_status = '0;
        m_d1 = '0;
        m_por = 1'b1;
        m_lvl = '0;
        for (int o = 0; o < NOUT; o++) begin
            m_ph[o] = 0;
            m_end[o] = 0;
            m_id[o] = '0;
        end
    endtask

    task automatic model_edge();
        logic [NW-1:0] set;
        logic [NW-1:0] hit;
        int low;
        m_cyc++;
        for (int i = 0; i < NW; i++)
            set[i] = rg_src_level[i] ? src_in[i] : (src_in[i] && !m_d1[i]);
        if (m_por) set[0] = 1'b1;
        for (int o = 0; o < NOUT; o++) begin
            hit = m_status & rg_int_enable[o*NW +: NW];
            case (m_ph[o])
                0: if (hit != '0) begin
                    low = -1;
                    for (int i = 0; i < NW; i++)
                        if (hit[i] && low < 0) low = i;
                    m_id[o] = low[IDW-1:0];
                    m_lvl[o] = rg_out_level_en[o];
                    m_ph[o] = 1;
                    m_end[o] = m_cyc + eff(rg_out_width[o*WW +: WW]);
                end
                1: if (m_lvl[o] ? (hit == '0) : (m_cyc == m_end[o])) begin
                    m_ph[o] = 2;
                    m_end[o] = m_cyc + eff(rg_out_cold[o*WW +: WW]);
                end
                default: if (m_cyc == m_end[o]) m_ph[o] = 0;
            endcase
        end
        m_status = (m_status & ~rg_int_clr) | set;
        m_d1 = src_in;
        m_por = 1'b0;
    endtask

    task automatic check(input string tag);
        logic [NOUT-1:0] eo;
        logic [NOUT*IDW-1:0] eid;
        for (int o = 0; o < NOUT; o++) begin
            eo[o] = (m_ph[o] == 1) ^ rg_out_low_en[o];
            eid[o*IDW +: IDW] = m_id[o];
        end
        total++;
        assert (int_out === eo) else begin
            bad++;
            $error("FAIL %s int_out got=%b exp=%b", tag, int_out, eo);
        end
        total++;
        assert (int_status === m_status) else begin
            bad++;
            $error("FAIL %s int_status got=%h exp=%h", tag, int_status, m_status);
        end
        total++;
        assert (int_src_id === eid) else begin
            bad++;
            $error("FAIL %s int_src_id got=%h exp=%h", tag, int_src_id, eid);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n, input string tag);
        repeat (n) begin
            if (rst) model_reset();
            else model_edge();
            @(posedge clk_32k);
            #1;
            check(tag);
        end
    endtask

    task automatic pulse_clr(input logic [NW-1:0] m);
        rg_int_clr = m;
        tick(1, "clr");
        rg_int_clr = '0;
    endtask

    task automatic wait_out(input int o, input logic lv, input int budget);
        int n = 0;
        while (int_out[o] !== lv && n < budget) begin
            tick(1, "wait");
            n++;
        end
        chk("wait_out_timeout", {31'd0, int_out[o]}, {31'd0, lv});
    endtask

    initial begin
        int cnt;
        model_reset();
        #1;
        check("reset");
        chk("reset_out", {30'd0, int_out}, 32'd0);

        // 1: power-on event, pulse train on out0
        rg_int_enable[0 +: NW] = 16'h0001;
        rg_out_width[0 +: WW] = 11'd4;
        rg_out_cold[0 +: WW] = 11'd8;
        tick(2, "in_rst");
        rst = 1'b0;
        tick(1, "t1");
        chk("t1_por_status", {16'd0, int_status}, 32'h0001);
        tick(1, "t1");
        chk("t1_out_hi", {31'd0, int_out[0]}, 32'd1);
        chk("t1_id", {28'd0, int_src_id[3:0]}, 32'd0);
        tick(3, "t1");
        chk("t1_w4_last", {31'd0, int_out[0]}, 32'd1);
        tick(1, "t1");
        chk("t1_w4_end", {31'd0, int_out[0]}, 32'd0);
        tick(40, "t1_train");
        pulse_clr(16'h0001);
        tick(30, "t1_post");
        chk("t1_quiet", {31'd0, int_out[0]}, 32'd0);

        // 2: edge source 5 to out1, level mode, active-low
        rg_int_enable[NW +: NW] = 16'h0020;
        rg_out_level_en[1] = 1'b1;
        rg_out_low_en[1] = 1'b1;
        rg_out_cold[WW +: WW] = 11'd6;
        src_in[5] = 1'b1;
        tick(1, "t2");
        chk("t2_status", {31'd0, int_status[5]}, 32'd1);
        chk("t2_inactive", {31'd0, int_out[1]}, 32'd1);
        tick(1, "t2");
        chk("t2_active_low", {31'd0, int_out[1]}, 32'd0);
        tick(98, "t2_hold");
        src_in[5] = 1'b0;
        tick(5, "t2_drop");
        chk("t2_still_low", {31'd0, int_out[1]}, 32'd0);
        pulse_clr(16'h0020);
        tick(1, "t2");
        chk("t2_release", {31'd0, int_out[1]}, 32'd1);
        tick(10, "t2_cold");

        // 3: level source 3, clear while high, set/clr collision
        rg_src_level[3] = 1'b1;
        src_in[3] = 1'b1;
        tick(2, "t3");
        pulse_clr(16'h0008);
        chk("t3_lvl_holds", {31'd0, int_status[3]}, 32'd1);
        src_in[3] = 1'b0;
        tick(1, "t3");
        pulse_clr(16'h0008);
        chk("t3_cleared", {31'd0, int_status[3]}, 32'd0);
        rg_src_level[3] = 1'b0;
        src_in[3] = 1'b1;
        rg_int_clr[3] = 1'b1;
        tick(1, "t3_coll");
        chk("t3_set_wins", {31'd0, int_status[3]}, 32'd1);
        rg_int_clr[3] = 1'b0;
        src_in[3] = 1'b0;
        pulse_clr(16'h0008);

        // 4: lowest-index ID
        rg_int_enable[0 +: NW] = 16'h0204;
        rg_out_width[0 +: WW] = 11'd3;
        rg_out_cold[0 +: WW] = 11'd4;
        src_in[2] = 1'b1;
        src_in[9] = 1'b1;
        tick(1, "t4");
        src_in = '0;
        wait_out(0, 1'b1, 5);
        chk("t4_id2", {28'd0, int_src_id[3:0]}, 32'd2);
        pulse_clr(16'h0004);
        wait_out(0, 1'b0, 10);
        wait_out(0, 1'b1, 20);
        chk("t4_id9", {28'd0, int_src_id[3:0]}, 32'd9);

        // 5: W=0/C=0 train, then 2047-cycle pulse with mid-pulse rewrite
        rg_out_width[0 +: WW] = 11'd0;
        rg_out_cold[0 +: WW] = 11'd0;
        wait_out(0, 1'b0, 10);
        wait_out(0, 1'b1, 20);
        tick(1, "t5");
        chk("t5_w1", {31'd0, int_out[0]}, 32'd0);
        tick(10, "t5_fast");
        rg_out_width[0 +: WW] = 11'd2047;
        rg_out_cold[0 +: WW] = 11'd2;
        wait_out(0, 1'b0, 5);
        wait_out(0, 1'b1, 10);
        rg_out_width[0 +: WW] = 11'd3;
        cnt = 1;
        while (int_out[0] === 1'b1 && cnt < 2100) begin
            tick(1, "t5_long");
            if (int_out[0] === 1'b1) cnt++;
        end
        chk("t5_w2047", cnt, 32'd2047);
        wait_out(0, 1'b1, 10);
        cnt = 1;
        while (int_out[0] === 1'b1 && cnt < 20) begin
            tick(1, "t5_new");
            if (int_out[0] === 1'b1) cnt++;
        end
        chk("t5_w3", cnt, 32'd3);
        pulse_clr(16'h0200);
        tick(10, "t5_end");

        // 6: async reset mid-assert on both pins
        rg_int_enable[0 +: NW] = 16'h0002;
        rg_out_width[0 +: WW] = 11'd50;
        src_in[1] = 1'b1;
        src_in[5] = 1'b1;
        tick(1, "t6");
        src_in = '0;
        tick(3, "t6");
        chk("t6_pre", {30'd0, int_out}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("t6_async");
        chk("t6_out_idle", {30'd0, int_out}, 32'd2);
        chk("t6_status0", {16'd0, int_status}, 32'd0);
        tick(2, "t6_rst");
        rst = 1'b0;
        tick(1, "t6_rel");
        chk("t6_por", {16'd0, int_status}, 32'h0001);
        tick(20, "t6_run");

        // random stress
        for (int k = 0; k < 1500; k++) begin
            src_in = NW'($urandom & $urandom & $urandom);
            rg_int_clr = NW'($urandom & $urandom);
            if ($urandom_range(0, 49) == 0) begin
                rg_src_level = NW'($urandom);
                rg_int_enable = {NW'($urandom), NW'($urandom)};
                rg_out_low_en = NOUT'($urandom);
                rg_out_level_en = NOUT'($urandom);
                rg_out_width = {WW'($urandom_range(0, 5)), WW'($urandom_range(0, 5))};
                rg_out_cold = {WW'($urandom_range(0, 5)), WW'($urandom_range(0, 5))};
            end
            tick(1, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/int_ctrl_mo.md
Name: int_ctrl_mo

Overview:
- Next-generation interrupt controller on clk_32k.
- Collects NW source flags into a sticky pending-status vector with per-source edge/level capture.
- Routes them through per-output enable masks to NOUT independent interrupt pins.
- Each pin has its own polarity, pulse/level mode, pulse width, minimum cold gap and latched source ID for fast host dispatch.

Parameters:
- NW, 16, number of interrupt sources.
- NOUT, 2, number of interrupt output pins.
- WW, 11, width of pulse-width and cold-time fields.
- RST_SRC_EN, 1: 1 = status[0] is also set once after reset release (power-on event); 0 = src_in[0] only.
- IDW, $clog2(NW), source-ID width (derived, not overridable).

Ports:
- clk_32k  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- src_in  in  NW  raw source flags, already in clk_32k domain
- rg_src_level  in  NW  per source: 0 = rising-edge capture, 1 = level capture
- rg_int_clr  in  NW  one-cycle write-1-to-clear pulses for int_status
- rg_int_enable  in  NOUT*NW  per-output masks; output o uses bits [o*NW +: NW]
- rg_out_low_en  in  NOUT  per pin: 1 = active-low
- rg_out_level_en  in  NOUT  per pin: 0 = pulse mode, 1 = level mode
- rg_out_width  in  NOUT*WW  pulse width in cycles; 0 treated as 1
- rg_out_cold  in  NOUT*WW  minimum inactive gap in cycles; 0 treated as 1
- int_status  out  NW  sticky pending status
- int_src_id  out  NOUT*IDW  lowest-index enabled pending source, latched at assertion
- int_out  out  NOUT  interrupt pins

Behaviour:
Reset:
- int_status = 0, src_in_d1 = 0, every FSM in IDLE, counters = 0, int_src_id = 0.
- int_out[o] = rg_out_low_en[o] (inactive level).

Capture:
- set[i] = rg_src_level[i] ? src_in[i] : (src_in[i] & ~src_in_d1[i]).
- If RST_SRC_EN=1, a one-shot flag raised on the first clk_32k edge after rst deasserts is ORed into set[0].
- int_status[i] sets on the edge after set[i] is high. It clears on the edge after rg_int_clr[i] is high.
- set and clr in the same cycle: set wins.
- Level source held high: status is re-set every cycle, so clear has no effect until the source drops.

Per output o:
- int_on[o] = |(int_status & mask_o), combinational.

FSM per output, states IDLE / ASSERT / COLD:
- IDLE -> ASSERT when int_on[o]=1.
  - Latch mode = rg_out_level_en[o].
  - Latch int_src_id[o] = lowest i with int_status[i] & mask_o[i].
  - Load cnt = W-1.
- ASSERT, pulse mode: cnt decrements each cycle. When cnt==0, go to COLD and load cnt = C-1. Pulse lasts exactly W cycles even if int_on drops or the mask changes.
- ASSERT, level mode: stays while int_on[o]=1. Goes to COLD on the first cycle int_on[o]=0, loading cnt = C-1.
- COLD: cnt decrements. When cnt==0, go to IDLE. Events arriving during COLD stay pending in int_status.
- IDLE with int_on still 1 re-enters ASSERT on the next edge, giving a pulse train W active / C inactive until cleared.
- Width/cold/mode are sampled only on state entry; mid-state register writes take effect on the next entry.
- int_out[o] = (state==ASSERT) XOR rg_out_low_en[o]. This is decoded from registered state only, with no combinational path from src_in.

Latency:
- Edge source rises, sampled at edge k → int_status high after k.
- int_out active after edge k+1 (2-cycle latency from source).

Other rules:
- Outputs are fully independent; a source may be routed to several pins.
- int_src_id holds its value until the next IDLE->ASSERT.
- Counters are WW bits and never wrap: they are loaded only with W-1 / C-1, where W, C ∈ [1, 2^WW-1].
- Asynchronous rst mid-operation returns everything to reset values immediately; the RST_SRC_EN event fires again after release.

Test Plan:
1. Reset release, RST_SRC_EN=1, mask0=0x0001, pulse, W=4, C=8, active-high → status[0]=1 one cycle after release; int_out[0] high exactly 4 cycles, low ≥8; pulse train repeats until rg_int_clr[0]; int_src_id[0]=0.
2. Edge source 5 raised and held 100 cycles, mask1 bit5, level mode, low_en=1 → int_out[1] low 2 cycles after rise; stays low after the source falls; goes high the cycle after clr; then ≥C cycles high before any re-assert.
3. Level source 3 held high, clr pulsed while high → status[3] stays 1; after the source drops, clr clears it; set and clr on the same cycle leave status=1.
4. Sources 9 and 2 set on the same cycle, both enabled on out0 → int_src_id[0]=2; clear 2, next assertion reports 9.
5. W=0, C=0 → 1-cycle pulse, 1-cycle gap. W=2047 with rg_out_width changed mid-pulse → current pulse stays 2047 cycles, the next pulse uses the new value.
6. Assert rst mid-ASSERT on both outputs → int_out returns to inactive and int_status=0 immediately; normal operation resumes after release.
